// File: rtl/game_pkg.sv
// Shared types and helpers for the countdown-timer game sequencer.
package game_pkg;
  localparam int BCD_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Parameter value (0..99) to {tens, ones} BCD pair for counter loads.
  function automatic logic [2*BCD_W-1:0] to_bcd(input int unsigned v);
    logic [BCD_W-1:0] t;
    logic [BCD_W-1:0] o;
    t = BCD_W'(v / 10);
    o = BCD_W'(v % 10);
    return {t, o};
  endfunction
endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter: synchronous load, enabled decrement, floors at 00.
module bcd_down_counter
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [2*BCD_W-1:0] load_val,
  input  logic               dec,
  output logic [BCD_W-1:0]   tens,
  output logic [BCD_W-1:0]   ones,
  output logic               is_one,
  output logic               is_zero
);
  assign is_zero = (tens == 4'd0) && (ones == 4'd0);
  assign is_one  = (tens == 4'd0) && (ones == 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens <= '0;
      ones <= '0;
    end else if (load) begin
      {tens, ones} <= load_val;
    end else if (dec && !is_zero) begin
      if (ones == 4'd0) begin
        ones <= 4'd9;
        tens <= tens - 4'd1;
      end else begin
        ones <= ones - 4'd1;
      end
    end
  end
endmodule

// File: rtl/game_sequencer.sv
// Round-level controller: READY -> PLAY (-> PAUSE) -> HOLD per round, then DONE.
// PAUSE support is built only when GAME_SEQ_PAUSE_EN is defined.
module game_sequencer
  import game_pkg::*;
#(
  parameter int GAME_SECONDS  = 60,
  parameter int READY_SECONDS = 3,
  parameter int HOLD_SECONDS  = 5,
  parameter int NUM_ROUNDS    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       one_second_pulse,
  output logic       prescaler_clr,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic [3:0] round_num,
  output logic [2:0] state_code,
  output logic       game_active,
  output logic       game_finished
);
  localparam logic [2*BCD_W-1:0] READY_BCD  = to_bcd(READY_SECONDS);
  localparam logic [2*BCD_W-1:0] GAME_BCD   = to_bcd(GAME_SECONDS);
  localparam logic [2*BCD_W-1:0] HOLD_BCD   = to_bcd(HOLD_SECONDS);
  localparam logic [3:0]         LAST_ROUND = 4'(NUM_ROUNDS);

  state_t             state, state_nxt;
  logic [3:0]         round_nxt;
  logic               clr_nxt;
  logic               load, dec;
  logic [2*BCD_W-1:0] load_val;
  logic               is_one, is_zero;
  logic               tick;

  assign tick       = one_second_pulse;
  assign state_code = state;

`ifndef GAME_SEQ_PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause;
`endif

  bcd_down_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .tens     (time_tens),
    .ones     (time_ones),
    .is_one   (is_one),
    .is_zero  (is_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      round_num     <= '0;
      prescaler_clr <= 1'b0;
      game_active   <= 1'b0;
      game_finished <= 1'b0;
    end else begin
      state         <= state_nxt;
      round_num     <= round_nxt;
      prescaler_clr <= clr_nxt;
      game_active   <= (state_nxt == S_PLAY);
      game_finished <= (state_nxt == S_DONE);
    end
  end

  // Priority: start > pause > tick. Each timed phase reloads the counter and clears the prescaler.
  always_comb begin
    state_nxt = state;
    round_nxt = round_num;
    clr_nxt   = 1'b0;
    load      = 1'b0;
    load_val  = '0;
    dec       = 1'b0;
    if (start) begin
      state_nxt = S_READY;
      round_nxt = 4'd1;
      load      = 1'b1;
      load_val  = READY_BCD;
      clr_nxt   = 1'b1;
    end else begin
      case (state)
        S_READY: begin
          if (tick && is_one) begin
            state_nxt = S_PLAY;
            load      = 1'b1;
            load_val  = GAME_BCD;
            clr_nxt   = 1'b1;
          end else if (tick) begin
            dec = 1'b1;
          end
        end
        S_PLAY: begin
          // Reaching 00 wins over a coincident pause.
          if (tick && is_one) begin
            state_nxt = S_HOLD;
            load      = 1'b1;
            load_val  = HOLD_BCD;
            clr_nxt   = 1'b1;
          end
`ifdef GAME_SEQ_PAUSE_EN
          else if (pause) begin
            state_nxt = S_PAUSE;
            dec       = tick;
          end
`endif
          else if (tick) begin
            dec = 1'b1;
          end
        end
`ifdef GAME_SEQ_PAUSE_EN
        S_PAUSE: begin
          if (pause) begin
            state_nxt = S_PLAY;
            clr_nxt   = 1'b1;
          end
        end
`endif
        S_HOLD: begin
          if (tick && is_one) begin
            if (round_num < LAST_ROUND) begin
              state_nxt = S_READY;
              round_nxt = round_num + 4'd1;
              load      = 1'b1;
              load_val  = READY_BCD;
              clr_nxt   = 1'b1;
            end else begin
              state_nxt = S_DONE;
              dec       = 1'b1;
            end
          end else if (tick) begin
            dec = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer (GAME=12, READY=3, HOLD=2, ROUNDS=2).
module tb_game_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, pause = 1'b0, tick = 1'b0;
  logic       prescaler_clr, game_active, game_finished;
  logic [3:0] time_tens, time_ones, round_num;
  logic [2:0] state_code;

  int checks = 0;
  int fails  = 0;

  localparam logic [2:0] NO = 3'b000, TK = 3'b001, PS = 3'b010, PT = 3'b011, ST = 3'b100;

  logic [2:0]  st_q[$];
  logic [17:0] sb[$];

  game_sequencer #(
    .GAME_SECONDS(12), .READY_SECONDS(3), .HOLD_SECONDS(2), .NUM_ROUNDS(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .one_second_pulse(tick),
    .prescaler_clr(prescaler_clr), .time_tens(time_tens), .time_ones(time_ones),
    .round_num(round_num), .state_code(state_code), .game_active(game_active),
    .game_finished(game_finished)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Expected observation: {state, tens, ones, round, clr, active, finished}.
  function automatic logic [17:0] mk(input int st, input int v, input int r, input bit c);
    return {3'(st), 4'(v / 10), 4'(v % 10), 4'(r), c, (st == 2), (st == 5)};
  endfunction

  function automatic logic [17:0] obs();
    return {state_code, time_tens, time_ones, round_num, prescaler_clr, game_active, game_finished};
  endfunction

  task automatic step(input logic [2:0] s);
    {start, pause, tick} = s;
    @(posedge clk); #1;
    {start, pause, tick} = NO;
  endtask

  task automatic push(input logic [2:0] s, input logic [17:0] e);
    st_q.push_back(s);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    logic [17:0] e;
    repeat (2) @(posedge clk);
    #1;
    e = mk(0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin fails++; $display("FAIL reset_state: got %h expected %h", obs(), e); end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) push(TK, mk(0, 0, 0, 0));
    while (sb.size() > 0) begin
      step(st_q.pop_front());
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin fails++; $display("FAIL idle_ticks: got %h expected %h", obs(), e); end
    end
  endtask

  task automatic test_start_and_wrap();
    logic [17:0] e;
    push(ST, mk(1, 3, 1, 1));
    push(NO, mk(1, 3, 1, 0));
    push(TK, mk(1, 2, 1, 0));
    push(TK, mk(1, 1, 1, 0));
    push(TK, mk(2, 12, 1, 1));
    for (int v = 11; v >= 9; v--) push(TK, mk(2, v, 1, 0));
    while (sb.size() > 0) begin
      step(st_q.pop_front());
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin fails++; $display("FAIL start_wrap: got %h expected %h", obs(), e); end
    end
  endtask

  task automatic test_full_game();
    logic [17:0] e;
    for (int v = 8; v >= 1; v--) push(TK, mk(2, v, 1, 0));
    push(TK, mk(4, 2, 1, 1));
    push(TK, mk(4, 1, 1, 0));
    push(TK, mk(1, 3, 2, 1));
    push(TK, mk(1, 2, 2, 0));
    push(TK, mk(1, 1, 2, 0));
    push(TK, mk(2, 12, 2, 1));
    for (int v = 11; v >= 1; v--) push(TK, mk(2, v, 2, 0));
    push(TK, mk(4, 2, 2, 1));
    push(TK, mk(4, 1, 2, 0));
    push(TK, mk(5, 0, 2, 0));
    push(NO, mk(5, 0, 2, 0));
    push(TK, mk(5, 0, 2, 0));
    push(PS, mk(5, 0, 2, 0));
    push(ST, mk(1, 3, 1, 1));
    while (sb.size() > 0) begin
      step(st_q.pop_front());
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin fails++; $display("FAIL full_game: got %h expected %h", obs(), e); end
    end
  endtask

`ifdef GAME_SEQ_PAUSE_EN
  task automatic test_pause();
    logic [17:0] e;
    push(ST, mk(1, 3, 1, 1));
    push(TK, mk(1, 2, 1, 0));
    push(TK, mk(1, 1, 1, 0));
    push(TK, mk(2, 12, 1, 1));
    for (int v = 11; v >= 7; v--) push(TK, mk(2, v, 1, 0));
    push(PS, mk(3, 7, 1, 0));
    for (int i = 0; i < 4; i++) push(TK, mk(3, 7, 1, 0));
    push(PS, mk(2, 7, 1, 1));
    push(TK, mk(2, 6, 1, 0));
    push(PT, mk(3, 5, 1, 0));
    push(PS, mk(2, 5, 1, 1));
    while (sb.size() > 0) begin
      step(st_q.pop_front());
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin fails++; $display("FAIL pause: got %h expected %h", obs(), e); end
    end
  endtask
`else
  task automatic test_pause_ignored();
    logic [17:0] e;
    push(ST, mk(1, 3, 1, 1));
    push(TK, mk(1, 2, 1, 0));
    push(TK, mk(1, 1, 1, 0));
    push(TK, mk(2, 12, 1, 1));
    for (int v = 11; v >= 7; v--) push(TK, mk(2, v, 1, 0));
    push(PS, mk(2, 7, 1, 0));
    push(PT, mk(2, 6, 1, 0));
    push(TK, mk(2, 5, 1, 0));
    while (sb.size() > 0) begin
      step(st_q.pop_front());
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin fails++; $display("FAIL pause_ignored: got %h expected %h", obs(), e); end
    end
  endtask
`endif

  task automatic test_tick_pause_at_end();
    logic [17:0] e;
    push(ST, mk(1, 3, 1, 1));
    push(TK, mk(1, 2, 1, 0));
    push(TK, mk(1, 1, 1, 0));
    push(TK, mk(2, 12, 1, 1));
    for (int v = 11; v >= 1; v--) push(TK, mk(2, v, 1, 0));
    push(PT, mk(4, 2, 1, 1));
    push(PS, mk(4, 2, 1, 0));
    while (sb.size() > 0) begin
      step(st_q.pop_front());
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin fails++; $display("FAIL tick_pause_end: got %h expected %h", obs(), e); end
    end
  endtask

  task automatic test_restart_and_reset();
    logic [17:0] e;
    push(ST, mk(1, 3, 1, 1));
    push(TK, mk(1, 2, 1, 0));
    push(TK, mk(1, 1, 1, 0));
    push(TK, mk(2, 12, 1, 1));
    for (int v = 11; v >= 5; v--) push(TK, mk(2, v, 1, 0));
    push(ST, mk(1, 3, 1, 1));
    push(TK, mk(1, 2, 1, 0));
    push(TK, mk(1, 1, 1, 0));
    push(TK, mk(2, 12, 1, 1));
    for (int v = 11; v >= 5; v--) push(TK, mk(2, v, 1, 0));
    while (sb.size() > 0) begin
      step(st_q.pop_front());
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin fails++; $display("FAIL restart: got %h expected %h", obs(), e); end
    end
    #2 rst = 1'b0;
    #1;
    e = mk(0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin fails++; $display("FAIL async_reset: got %h expected %h", obs(), e); end
    @(posedge clk); #1;
    checks++;
    if (obs() !== e) begin fails++; $display("FAIL reset_hold: got %h expected %h", obs(), e); end
    rst = 1'b1;
    step(TK);
    checks++;
    if (obs() !== e) begin fails++; $display("FAIL after_reset: got %h expected %h", obs(), e); end
  endtask

  initial begin
    test_reset();
    test_start_and_wrap();
    test_full_game();
`ifdef GAME_SEQ_PAUSE_EN
    test_pause();
`else
    test_pause_ignored();
`endif
    test_tick_pause_at_end();
    test_restart_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
